// File: rtl/pipe_mon_pkg.sv
// Shared types and constants for the pipeline performance monitor.
// States, done reasons, readout selects and RV32 opcode classes.
package pipe_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RSN_NONE  = 2'b00,
      RSN_HALT  = 2'b01,
      RSN_LIMIT = 2'b10
   } reason_e;

   localparam logic [3:0] SEL_CYCLE   = 4'd0;
   localparam logic [3:0] SEL_RETIRE  = 4'd1;
   localparam logic [3:0] SEL_STALL   = 4'd2;
   localparam logic [3:0] SEL_BRANCH  = 4'd3;
   localparam logic [3:0] SEL_FWD     = 4'd4;
   localparam logic [3:0] SEL_STATUS  = 4'd5;
   localparam logic [3:0] SEL_H_R     = 4'd6;
   localparam logic [3:0] SEL_H_I     = 4'd7;
   localparam logic [3:0] SEL_H_LOAD  = 4'd8;
   localparam logic [3:0] SEL_H_STORE = 4'd9;
   localparam logic [3:0] SEL_H_BR    = 4'd10;
   localparam logic [3:0] SEL_H_OTHER = 4'd11;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam int NHIST = 6;

   // One-hot opcode class in histogram order: R, I, load, store, branch, other.
   function automatic logic [NHIST-1:0] op_class(input logic [6:0] op);
      logic [NHIST-1:0] c;
      c = '0;
      unique case (op)
         OP_R:      c[0] = 1'b1;
         OP_I:      c[1] = 1'b1;
         OP_LOAD:   c[2] = 1'b1;
         OP_STORE:  c[3] = 1'b1;
         OP_BRANCH: c[4] = 1'b1;
         default:   c[5] = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipeline_perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and a variable increment.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W  = 32,
   parameter int IW = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic [IW-1:0] inc,
   output logic [W-1:0]  value
);

   localparam int SW = W + 1;

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;
   logic [W:0]   sum;

   assign sum = {1'b0, value_q} + SW'(inc);

   // Next value: clear wins, otherwise add and clamp on carry-out.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (sum[W]) begin
         value_d = '1;
      end else begin
         value_d = sum[W-1:0];
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Run-control and performance monitor beside the pipelined core.
// Optional opcode histogram enabled by defining PIPE_MON_HIST_EN.
module pipeline_perf_monitor
   import pipe_mon_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 500,
   parameter int HALT_ZEROS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             instr_valid,
   input  logic [31:0]      instr_if,
   input  logic             retire_valid,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [1:0]       fwd_a,
   input  logic [1:0]       fwd_b,
   input  logic [3:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic             running,
   output logic             done,
   output logic [1:0]       done_reason
);

   localparam int ZW = (HALT_ZEROS < 2) ? 1 : $clog2(HALT_ZEROS + 1);
   localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [ZW-1:0]    HZ_LAST  = ZW'(HALT_ZEROS - 1);

   state_e           state_q, state_d;
   reason_e          rsn_q, rsn_d;
   logic [ZW-1:0]    zrun_q, zrun_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   logic             run;
   logic             clr;
   logic             fetch_zero;
   logic             halt;
   logic             limit;
   logic [1:0]       fwd_inc;

   logic [CNT_W-1:0] cyc_v;
   logic [CNT_W-1:0] ret_v;
   logic [CNT_W-1:0] stl_v;
   logic [CNT_W-1:0] br_v;
   logic [CNT_W-1:0] fwd_v;

   assign run        = (state_q == ST_RUN);
   assign fetch_zero = instr_valid && (instr_if == 32'd0);
   assign halt       = run && fetch_zero && (zrun_q == HZ_LAST);
   assign limit      = run && (cyc_v == CYC_LAST);
   assign fwd_inc    = {1'b0, run & (|fwd_a)} + {1'b0, run & (|fwd_b)};

   // Run control: start clears, halt beats the cycle limit.
   always_comb begin
      state_d = state_q;
      rsn_d   = rsn_q;
      zrun_d  = zrun_q;
      clr     = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               rsn_d   = RSN_NONE;
               zrun_d  = '0;
               clr     = 1'b1;
            end
         end
         ST_RUN: begin
            if (instr_valid) begin
               zrun_d = fetch_zero ? zrun_q + 1'b1 : '0;
            end
            if (halt) begin
               state_d = ST_DONE;
               rsn_d   = RSN_HALT;
            end else if (limit) begin
               state_d = ST_DONE;
               rsn_d   = RSN_LIMIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rsn_q   <= RSN_NONE;
         zrun_q  <= '0;
      end else begin
         state_q <= state_d;
         rsn_q   <= rsn_d;
         zrun_q  <= zrun_d;
      end
   end

   sat_counter #(.W(CNT_W), .IW(1)) u_cyc (
      .clk(clk), .reset(reset), .clr(clr),
      .inc(run), .value(cyc_v)
   );

   sat_counter #(.W(CNT_W), .IW(1)) u_ret (
      .clk(clk), .reset(reset), .clr(clr),
      .inc(run & retire_valid), .value(ret_v)
   );

   sat_counter #(.W(CNT_W), .IW(1)) u_stl (
      .clk(clk), .reset(reset), .clr(clr),
      .inc(run & stall), .value(stl_v)
   );

   sat_counter #(.W(CNT_W), .IW(1)) u_br (
      .clk(clk), .reset(reset), .clr(clr),
      .inc(run & branch_taken), .value(br_v)
   );

   sat_counter #(.W(CNT_W), .IW(2)) u_fwd (
      .clk(clk), .reset(reset), .clr(clr),
      .inc(fwd_inc), .value(fwd_v)
   );

`ifdef PIPE_MON_HIST_EN
   logic [NHIST-1:0] hist_inc;
   logic [CNT_W-1:0] hist_v [NHIST];

   assign hist_inc = {NHIST{run & instr_valid}} & op_class(instr_if[6:0]);

   for (genvar g = 0; g < NHIST; g++) begin : g_hist
      sat_counter #(.W(CNT_W), .IW(1)) u_h (
         .clk(clk), .reset(reset), .clr(clr),
         .inc(hist_inc[g]), .value(hist_v[g])
      );
   end
`endif

   // Readout mux over pre-update values.
   always_comb begin
      rd_data_d = '0;
      unique case (rd_sel)
         SEL_CYCLE:   rd_data_d = cyc_v;
         SEL_RETIRE:  rd_data_d = ret_v;
         SEL_STALL:   rd_data_d = stl_v;
         SEL_BRANCH:  rd_data_d = br_v;
         SEL_FWD:     rd_data_d = fwd_v;
         SEL_STATUS:  rd_data_d = CNT_W'({rsn_q, state_q == ST_DONE, run});
`ifdef PIPE_MON_HIST_EN
         SEL_H_R:     rd_data_d = hist_v[0];
         SEL_H_I:     rd_data_d = hist_v[1];
         SEL_H_LOAD:  rd_data_d = hist_v[2];
         SEL_H_STORE: rd_data_d = hist_v[3];
         SEL_H_BR:    rd_data_d = hist_v[4];
         SEL_H_OTHER: rd_data_d = hist_v[5];
`endif
         default:     rd_data_d = '0;
      endcase
   end

   // Registered readout port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign running     = run;
   assign done        = (state_q == ST_DONE);
   assign done_reason = rsn_q;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Self-checking bench for pipeline_perf_monitor: two instances, one model.
// Histogram expectations follow PIPE_MON_HIST_EN.
module tb_pipeline_perf_monitor;

   localparam int W    = 8;
   localparam int SATV = 255;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr_if = 32'd0;
   logic        retire_valid = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [1:0]  fwd_a = 2'd0;
   logic [1:0]  fwd_b = 2'd0;
   logic [3:0]  rd_sel = 4'd0;

   logic [W-1:0] rd_o  [2];
   logic         run_o [2];
   logic         done_o[2];
   logic [1:0]   rsn_o [2];

   always #5 clk = ~clk;

   pipeline_perf_monitor #(
      .CNT_W(W), .MAX_CYCLES(200), .HALT_ZEROS(1)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start),
      .instr_valid(instr_valid), .instr_if(instr_if),
      .retire_valid(retire_valid), .stall(stall),
      .branch_taken(branch_taken), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .rd_sel(rd_sel), .rd_data(rd_o[0]), .running(run_o[0]),
      .done(done_o[0]), .done_reason(rsn_o[0])
   );

   pipeline_perf_monitor #(
      .CNT_W(W), .MAX_CYCLES(6), .HALT_ZEROS(2)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start),
      .instr_valid(instr_valid), .instr_if(instr_if),
      .retire_valid(retire_valid), .stall(stall),
      .branch_taken(branch_taken), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .rd_sel(rd_sel), .rd_data(rd_o[1]), .running(run_o[1]),
      .done(done_o[1]), .done_reason(rsn_o[1])
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---- behavioural model: state 0 idle, 1 run, 2 done ----
   int p_max[2] = '{200, 6};
   int p_hz [2] = '{1, 2};
   int m_st [2];
   int m_rsn[2];
   int m_zr [2];
   int m_rd [2];
   int m_c  [2][5];
   int m_h  [2][6];
   int c_old, z_old;
   bit zf;

   function automatic int sat(int v);
      return (v > SATV) ? SATV : v;
   endfunction

   function automatic int hclass(logic [31:0] ins);
      case (ins[6:0])
         7'b0110011: return 0;
         7'b0010011: return 1;
         7'b0000011: return 2;
         7'b0100011: return 3;
         7'b1100011: return 4;
         default:    return 5;
      endcase
   endfunction

   function automatic int mval(int i, logic [3:0] s);
      int k;
      k = int'(s);
      if (k <= 4) return m_c[i][k];
      if (k == 5) return m_rsn[i] * 4 + (m_st[i] == 2 ? 2 : 0) + (m_st[i] == 1 ? 1 : 0);
`ifdef PIPE_MON_HIST_EN
      if (k <= 11) return m_h[i][k-6];
`endif
      return 0;
   endfunction

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_rsn[i] = 0; m_zr[i] = 0; m_rd[i] = 0;
            for (int k = 0; k < 5; k++) m_c[i][k] = 0;
            for (int k = 0; k < 6; k++) m_h[i][k] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_rd[i] = mval(i, rd_sel);
            if (m_st[i] == 1) begin
               c_old = m_c[i][0];
               z_old = m_zr[i];
               zf = instr_valid && (instr_if == 32'd0);
               m_c[i][0] = sat(c_old + 1);
               m_c[i][1] = sat(m_c[i][1] + int'(retire_valid));
               m_c[i][2] = sat(m_c[i][2] + int'(stall));
               m_c[i][3] = sat(m_c[i][3] + int'(branch_taken));
               m_c[i][4] = sat(m_c[i][4] + int'(fwd_a != 0) + int'(fwd_b != 0));
               if (instr_valid) begin
                  m_h[i][hclass(instr_if)] = sat(m_h[i][hclass(instr_if)] + 1);
                  m_zr[i] = zf ? z_old + 1 : 0;
               end
               if (zf && z_old == p_hz[i] - 1) begin
                  m_st[i] = 2; m_rsn[i] = 1;
               end else if (c_old == p_max[i] - 1) begin
                  m_st[i] = 2; m_rsn[i] = 2;
               end
            end else if (start) begin
               for (int k = 0; k < 5; k++) m_c[i][k] = 0;
               for (int k = 0; k < 6; k++) m_h[i][k] = 0;
               m_zr[i] = 0; m_rsn[i] = 0; m_st[i] = 1;
            end
         end
      end
   end

   // ---- per-cycle compare against the model ----
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("cyc_running[%0d]", i), 32'(run_o[i]), 32'(m_st[i] == 1));
            check($sformatf("cyc_done[%0d]", i), 32'(done_o[i]), 32'(m_st[i] == 2));
            check($sformatf("cyc_reason[%0d]", i), 32'(rsn_o[i]), m_rsn[i]);
            check($sformatf("cyc_rd_data[%0d]", i), 32'(rd_o[i]), m_rd[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] s, output int a, output int b);
      rd_sel = s;
      tick();
      a = int'(rd_o[0]);
      b = int'(rd_o[1]);
   endtask

   int a, b, h;

   initial begin
`ifdef PIPE_MON_HIST_EN
      h = 1;
`else
      h = 0;
`endif
      #1;
      check("reset_rd_data", 32'(rd_o[0]), 0);
      check("reset_running", 32'(run_o[0]), 0);
      check("reset_done", 32'(done_o[0]), 0);
      check("reset_reason", 32'(rsn_o[0]), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();

      // halt after 20 nonzero fetches; instance b hits its 6-cycle limit
      start = 1'b1; tick(); start = 1'b0;
      instr_valid = 1'b1; instr_if = 32'h00000013; retire_valid = 1'b1;
      repeat (20) tick();
      instr_if = 32'd0; tick();
      instr_valid = 1'b0; retire_valid = 1'b0;
      check("halt_done", 32'(done_o[0]), 1);
      check("halt_reason", 32'(rsn_o[0]), 1);
      check("limit_reason", 32'(rsn_o[1]), 2);
      rd(4'd0, a, b);
      check("halt_cycle", a, 21);
      check("limit_cycle", b, 6);
      rd(4'd1, a, b);
      check("halt_retire", a, 21);

      // stalls with PC held, then a single zero fetch (b needs two)
      start = 1'b1; tick(); start = 1'b0;
      stall = 1'b1; repeat (3) tick(); stall = 1'b0;
      instr_valid = 1'b1; instr_if = 32'd0; tick(); instr_valid = 1'b0;
      check("zr1_still_running", 32'(run_o[1]), 1);
      check("zr1_a_halted", 32'(rsn_o[0]), 1);
      rd(4'd2, a, b);
      check("stall_cnt", b, 3);
      // second zero fetch coincides with b's cycle limit
      instr_valid = 1'b1; tick(); instr_valid = 1'b0;
      check("tie_reason", 32'(rsn_o[1]), 1);
      rd(4'd0, a, b);
      check("tie_cycle", b, 6);
      check("zr1_a_cycle", a, 4);

      // forwarding saturation over 200 cycles
      start = 1'b1; tick(); start = 1'b0;
      rd_sel = 4'd4; instr_valid = 1'b1; instr_if = 32'h00000013;
      fwd_a = 2'b01; fwd_b = 2'b01;
      repeat (200) tick();
      fwd_a = 2'b00; fwd_b = 2'b00; instr_valid = 1'b0;
      check("sat_done_reason", 32'(rsn_o[0]), 2);
      rd(4'd4, a, b);
      check("fwd_saturated", a, 255);
      check("fwd_b_six", b, 12);
      rd(4'd0, a, b);
      check("sat_cycle", a, 200);

      // asynchronous reset mid-run
      start = 1'b1; tick(); start = 1'b0;
      rd_sel = 4'd0;
      repeat (3) tick();
      #2 reset = 1'b1;
      #1;
      check("arst_running", 32'(run_o[0]), 0);
      check("arst_done", 32'(done_o[0]), 0);
      check("arst_reason", 32'(rsn_o[1]), 0);
      check("arst_rd_data", 32'(rd_o[0]), 0);
      #1 reset = 1'b0;
      tick();

      // opcode histogram
      start = 1'b1; tick(); start = 1'b0;
      instr_valid = 1'b1;
      instr_if = 32'h00500093; tick();
      instr_if = 32'h002081B3; tick();
      instr_if = 32'h0000A103; tick();
      instr_valid = 1'b0;
      rd(4'd7, a, b);
      check("hist_i", a, h);
      rd(4'd6, a, b);
      check("hist_r", a, h);
      rd(4'd8, a, b);
      check("hist_load", a, h);
      rd(4'd9, a, b);
      check("hist_store", a, 0);
      rd(4'd12, a, b);
      check("sel_unused", a, 0);
      rd(4'd5, a, b);
      check("status_running", a, 1);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pipeline_perf_monitor.md
# pipeline_perf_monitor

Synthesizable run-control and performance monitor for the pipelined RISC-V core. It generalises the bench-only cycle/halt/instruction-class reporting into hardware: it runs a bounded measurement window, detects program halt on fetched all-zero instructions, and counts cycles, retirements, stalls, taken branches and forwarding events in saturating counters. Results are read back through a registered select port. It sits beside `pipelined_processor` and taps its fetch, hazard, forwarding and writeback signals.

## Interface
- `CNT_W`, 32: width of every counter and of `rd_data`; minimum 8.
- `MAX_CYCLES`, 500: cycle budget per run; range 1 to 2^CNT_W-1.
- `HALT_ZEROS`, 1: consecutive valid all-zero fetches that signal halt; minimum 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse; begins a run with counters cleared.
- `instr_valid`  in  1  `instr_if` is a real fetch this cycle (low while the PC is held).
- `instr_if`  in  32  fetched instruction.
- `retire_valid`  in  1  MEM/WB stage writes back or completes this cycle.
- `stall`  in  1  hazard unit holds the PC this cycle.
- `branch_taken`  in  1  EX/MEM branch resolved taken.
- `fwd_a`, `fwd_b`  in  2 each  forwarding-unit selects.
- `rd_sel`  in  4  readout register select.
- `rd_data`  out  CNT_W  selected register, valid one cycle after `rd_sel`.
- `running`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `done_reason`  out  2  00 none, 01 halt, 10 cycle limit.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE with `start`: go to RUN. All counters, the zero-run counter and `done_reason` clear to 0.
- `start` in RUN is ignored.
- Counting happens only in RUN, and includes the cycle that leaves RUN:
  - `cycle_cnt` +1 every cycle.
  - `retire_cnt` +1 on `retire_valid`.
  - `stall_cnt` +1 on `stall`.
  - `branch_cnt` +1 on `branch_taken`.
  - `fwd_cnt` +0, +1 or +2 per cycle, one for each of `fwd_a` and `fwd_b` that is nonzero.
- All counters saturate at 2^CNT_W-1. An increment of +2 at all-ones minus 1 gives all-ones.
- Zero-run counter:
  - +1 on `instr_valid && instr_if==0`.
  - Cleared on `instr_valid && instr_if!=0`.
  - Held when `instr_valid` is low.
- Halt: when the zero-run counter equals HALT_ZEROS-1 and the current fetch is a valid zero, go to DONE with reason 01.
- Cycle limit: when `cycle_cnt` equals MAX_CYCLES-1, go to DONE with reason 10.
- If halt and cycle limit occur on the same cycle, halt wins (reason 01).
- DONE holds all counters until the next `start`.
- `rd_sel` codes:
  - 0 cycle, 1 retire, 2 stall, 3 branch, 4 fwd.
  - 5 status, packed as {zeros, done_reason, done, running}.
  - 6–11 histogram (see Configuration).
  - Any other code reads 0.

## Timing
- After reset: `rd_data`=0, `running`=0, `done`=0, `done_reason`=00, all counters 0.
- `start` sampled at edge N: `running`=1 after edge N. `cycle_cnt` becomes 1 at edge N+1.
- A run of MAX_CYCLES with no halt: `done` rises after the MAX_CYCLES-th RUN edge, with `cycle_cnt`=MAX_CYCLES.
- Readout latency is one cycle: `rd_data` after edge N reflects `rd_sel` and counter values sampled at edge N (the pre-update value).
- Reset asserted mid-run: immediate return to IDLE and all outputs 0, regardless of the clock.

## Configuration
- Macro: `PIPE_MON_HIST_EN`.
- Defined: six extra saturating counters, incremented in RUN on `instr_valid` by `instr_if[6:0]`:
  - R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011, other.
  - Read at `rd_sel` 6–11 in that order.
- Undefined: the histogram counters do not exist and `rd_sel` 6–11 read 0.

## Structure
- Package `pipe_mon_pkg`: state enum, `done_reason` codes, `rd_sel` codes, RV32 opcode constants.
- Sub-module `sat_counter`: parameters width and increment width; ports clear, inc amount, value. Instantiated once per counter.

## Test plan
- Reset, `start`, 20 cycles of nonzero valid fetches, then `instr_if`=0 valid (HALT_ZEROS=1) → DONE, `done_reason`=01, `cycle_cnt`=21.
- MAX_CYCLES=6 with no zero fetch → `done` after the 6th RUN edge, `cycle_cnt`=6, reason 10.
- `stall` high for 3 cycles with `instr_valid` low and `instr_if`=0, then a zero fetch with HALT_ZEROS=2 → no halt yet (zero-run=1), `stall_cnt`=3.
- CNT_W=8, `fwd_a`=`fwd_b`=01 for 200 cycles → `fwd_cnt`=255 (saturated), not wrapped.
- Halt and cycle limit on the same cycle → reason 01. `reset` asserted mid-run → all outputs 0 before the next edge.
- With `PIPE_MON_HIST_EN`: fetch sequence 0x00500093, 0x002081B3, 0x0000A103 → `rd_sel` 7, 6, 8 each read 1. Without the macro: `rd_sel` 7 reads 0.
